// File: rtl/tc_fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
//   state_e     : sequencer control state
//   COUNT_WIDTH : width of the retired-instruction counter
package tc_fetch_pkg;

    localparam int unsigned StateWidth  = 3;
    localparam int unsigned COUNT_WIDTH = 32;

    typedef enum logic [StateWidth-1:0] {
        StResetWait = 3'd0,
        StHalted    = 3'd1,
        StRun       = 3'd2,
        StStep      = 3'd3,
        StFault     = 3'd4
    } state_e;

endpackage

// File: rtl/tc_fetch_sequencer.sv
// Instruction-fetch controller for a 4-word-wide registered program memory.
// Owns the PC, drives the memory address with the combinational next PC so the
// registered window always lines up with the PC, and hands the window to the
// decoder through a valid/ready handshake with variable instruction length.
//   clk, rst              : clock, asynchronous active-high reset
//   mem_addr_o            : program memory address (next PC)
//   mem_out0_i..3_i       : registered memory words mem[a..a+3]
//   inst_w0_o..3_o        : window presented to the decoder
//   inst_pc_o             : address of inst_w0_o
//   inst_valid_o          : window valid
//   inst_ready_i          : decoder accepts, consuming inst_len_i+1 words
//   redirect_valid_i/pc_i : jump request
//   run/step/halt_req_i   : execution control pulses
//   bp_en_i, bp_addr_i    : breakpoint
//   halted_o, fault_o     : state indicators
//   bp_hit_o              : one-cycle pulse on breakpoint stop
//   retired_count_o       : accepted instructions, wrapping
module tc_fetch_sequencer
    import tc_fetch_pkg::*;
#(
    parameter int unsigned BIT_WIDTH  = 16,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned MEM_WORDS  = 256,
    parameter int unsigned RESET_PC   = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic [ADDR_WIDTH-1:0]  mem_addr_o,
    input  logic [BIT_WIDTH-1:0]   mem_out0_i,
    input  logic [BIT_WIDTH-1:0]   mem_out1_i,
    input  logic [BIT_WIDTH-1:0]   mem_out2_i,
    input  logic [BIT_WIDTH-1:0]   mem_out3_i,
    output logic [BIT_WIDTH-1:0]   inst_w0_o,
    output logic [BIT_WIDTH-1:0]   inst_w1_o,
    output logic [BIT_WIDTH-1:0]   inst_w2_o,
    output logic [BIT_WIDTH-1:0]   inst_w3_o,
    output logic [ADDR_WIDTH-1:0]  inst_pc_o,
    output logic                   inst_valid_o,
    input  logic                   inst_ready_i,
    input  logic [1:0]             inst_len_i,
    input  logic                   redirect_valid_i,
    input  logic [ADDR_WIDTH-1:0]  redirect_pc_i,
    input  logic                   run_req_i,
    input  logic                   step_req_i,
    input  logic                   halt_req_i,
    input  logic                   bp_en_i,
    input  logic [ADDR_WIDTH-1:0]  bp_addr_i,
    output logic                   halted_o,
    output logic                   fault_o,
    output logic                   bp_hit_o,
    output logic [COUNT_WIDTH-1:0] retired_count_o
);

    // Bounds are compared one bit wider than the PC so pc+len never wraps.
    localparam logic [ADDR_WIDTH:0] MemLimit = (ADDR_WIDTH+1)'(MEM_WORDS);

    state_e                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic                   bp_hit_q, bp_hit_d;

    logic                   valid;
    logic                   fire;
    logic                   fire_oob;
    logic                   redirect_oob;
    logic [ADDR_WIDTH-1:0]  seq_pc;

    assign valid        = (state_q == StRun) || (state_q == StStep);
    assign fire         = valid & inst_ready_i;
    assign fire_oob     = fire && (({1'b0, pc_q} + (ADDR_WIDTH+1)'(inst_len_i)) >= MemLimit);
    assign redirect_oob = ({1'b0, redirect_pc_i} >= MemLimit);
    assign seq_pc       = pc_q + ADDR_WIDTH'(inst_len_i) + ADDR_WIDTH'(1);

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        count_d  = count_q;
        bp_hit_d = 1'b0;
        case (state_q)
            // One edge lets the memory load the window at the reset PC.
            StResetWait: state_d = StHalted;
            StFault: begin
                if (redirect_valid_i) begin
                    pc_d = redirect_pc_i;
                    if (!redirect_oob) state_d = StHalted;
                end
            end
            default: begin
                if (fire_oob) begin
                    // Faulting fetch: PC holds, nothing retires, redirect is dropped.
                    state_d = StFault;
                end else begin
                    if (fire) begin
                        count_d = count_q + COUNT_WIDTH'(1);
                        pc_d    = seq_pc;
                    end
                    // A redirect alongside a fire is a retiring jump.
                    if (redirect_valid_i) pc_d = redirect_pc_i;

                    if (redirect_valid_i && redirect_oob) begin
                        state_d = StFault;
                    end else if (state_q == StHalted) begin
                        if (step_req_i)     state_d = StStep;
                        else if (run_req_i) state_d = StRun;
                    end else if (state_q == StStep) begin
                        if (fire) state_d = StHalted;
                    end else begin
                        // Stop before presenting the breakpoint address.
                        if (bp_en_i && (pc_d != pc_q) && (pc_d == bp_addr_i)) begin
                            state_d  = StHalted;
                            bp_hit_d = 1'b1;
                        end else if (halt_req_i) begin
                            state_d = StHalted;
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StResetWait;
            pc_q     <= ADDR_WIDTH'(RESET_PC);
            count_q  <= '0;
            bp_hit_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            count_q  <= count_d;
            bp_hit_q <= bp_hit_d;
        end
    end

    assign mem_addr_o      = pc_d;
    assign inst_w0_o       = mem_out0_i;
    assign inst_w1_o       = mem_out1_i;
    assign inst_w2_o       = mem_out2_i;
    assign inst_w3_o       = mem_out3_i;
    assign inst_pc_o       = pc_q;
    assign inst_valid_o    = valid;
    assign halted_o        = (state_q == StHalted);
    assign fault_o         = (state_q == StFault);
    assign bp_hit_o        = bp_hit_q;
    assign retired_count_o = count_q;

endmodule

// File: doc/tc_fetch_sequencer.md
Name: tc_fetch_sequencer

Overview:
Instruction-fetch controller for the 4-word-wide program memory, which registers mem[a], mem[a+1], mem[a+2] and mem[a+3] one clock after address a.
- Owns the program counter and drives the memory address.
- Presents the 4-word window to the decoder with a valid/ready handshake and variable instruction length (1–4 words).
- Provides run/halt/single-step control, breakpoint, jump redirect, bounds fault and a retired-instruction counter.

Parameters:
BIT_WIDTH, 16, program word width
ADDR_WIDTH, 16, program counter / memory address width
MEM_WORDS, 256, number of valid program words; fetches at or beyond this fault
RESET_PC, 0, PC value after reset

Ports:
clk  in  1  clock
rst  in  1  reset
mem_addr  out  ADDR_WIDTH  address to program memory; combinational pc_next
mem_out0..mem_out3  in  BIT_WIDTH each  memory read words (registered in memory)
inst_w0..inst_w3  out  BIT_WIDTH each  pass-through of mem_out0..3
inst_pc  out  ADDR_WIDTH  address of inst_w0 (= pc)
inst_valid  out  1  window valid
inst_ready  in  1  decoder accepts instruction
inst_len  in  2  words consumed minus 1 (0→1 word … 3→4 words)
redirect_valid  in  1  jump request
redirect_pc  in  ADDR_WIDTH  jump target
run_req  in  1  pulse: HALTED→RUN
step_req  in  1  pulse: HALTED→STEP
halt_req  in  1  pulse: RUN→HALTED
bp_en  in  1  breakpoint enable
bp_addr  in  ADDR_WIDTH  breakpoint address
halted  out  1  state is HALTED
fault  out  1  state is FAULT
bp_hit  out  1  one-cycle pulse on breakpoint stop
retired_count  out  32  accepted instructions, wraps

Behaviour:
- Reset: rst is asynchronous, active-high; clk is the clock. Reset values: state=RESET_WAIT, pc=RESET_PC, retired_count=0, bp_hit=0, inst_valid=0, halted=0, fault=0.
- The memory captures mem_addr on the same edge the sequencer loads pc<=pc_next. The window therefore always matches pc one cycle later, with no bubble on sequential flow or on redirect.
- fire = inst_valid & inst_ready.
- seq = pc + inst_len + 1, computed mod 2^ADDR_WIDTH.
- pc_next priority:
  - redirect_valid (states other than RESET_WAIT): redirect_pc.
  - else fire: seq.
  - else: pc.
- States:
  - RESET_WAIT: inst_valid=0; redirect and requests ignored. Next edge → HALTED, which gives the memory one edge to load the window at RESET_PC.
  - HALTED: inst_valid=0, halted=1. step_req → STEP. Else run_req → RUN. Both together → STEP.
  - RUN: inst_valid=1. halt_req → HALTED after this cycle; a fire in the same cycle is still honoured.
  - STEP: inst_valid=1. The first fire → HALTED.
  - FAULT: inst_valid=0, fault=1. Only redirect_valid with an in-range target (→ HALTED) or rst exits.
- Bounds fault:
  - Condition: fire with pc + inst_len ≥ MEM_WORDS, computed at ADDR_WIDTH+1 bits with no wrap.
  - Response: state → FAULT, pc unchanged, retired_count not incremented.
  - Also: a redirect to a target ≥ MEM_WORDS → FAULT, pc=target.
- Redirect in the same cycle as fire:
  - The fire retires (count+1), then the PC jumps. This is the jump-instruction case.
  - If the fired instruction is itself out of bounds, the fault wins.
- Breakpoint:
  - In RUN, with bp_en, if pc_next == bp_addr on an edge where pc changes, state → HALTED and bp_hit=1 for one cycle.
  - The instruction at bp_addr is presented only after the next run_req or step_req.
  - STEP ignores breakpoints.
- retired_count: +1 per non-faulting fire; wraps at 2^32.
- While inst_valid=0, inst_ready is don't-care; no retire occurs.
- Reset mid-operation: all state returns to reset values immediately; the decoder sees inst_valid drop asynchronously.

Decomposition:
- Package tc_fetch_pkg holds:
  - the state enum {RESET_WAIT, HALTED, RUN, STEP, FAULT} and its encoding width;
  - the constant COUNT_WIDTH=32.
- No sub-module; the PC-next/bounds logic stays inline. The bench instantiates the existing program-word memory alongside.

Test Plan:
- Reset with RESET_PC=0 → cycle 1 inst_valid=0, halted=1. Then run_req, and fire with inst_len=1 each cycle → inst_pc sequence 0,2,4,6 at 1 per cycle; retired_count=3 after 3 fires.
- HALTED at pc=5, step_req, inst_ready=1, inst_len=3 → exactly one fire; pc=9; halted=1; retired_count+1.
- RUN at pc=10, fire with redirect_valid, redirect_pc=0x40 → next inst_pc=0x40 with window mem[0x40..0x43] and no bubble; count+1.
- bp_en, bp_addr=8, RUN from 0 with inst_len=3 → stop with pc=8, bp_hit pulse, inst_valid=0. Then run_req → inst_pc=8 is presented.
- MEM_WORDS=256, pc=254, fire with inst_len=2 → fault=1, pc=254, count unchanged. redirect_pc=300 → still FAULT. redirect_pc=0 → HALTED.
- Assert rst during RUN mid-stream → inst_valid=0 immediately, count=0, pc=RESET_PC. Simultaneous halt_req+fire → fire retired, then HALTED.
